// File: rtl/channel_mixer_pkg.sv
// Shared types and sizing helpers for the per-sample channel mixer.
package channel_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_WAIT,
        ST_ACCUM,
        ST_SAT,
        ST_OUT
    } channel_mixer_state_t;

    // Low five bits of a channel config word; attenuation sits above these.
    typedef struct packed {
        logic chd;
        logic chc;
        logic chb;
        logic cha;
        logic cnt;
    } channel_cfg_t;

    localparam int CH_MIX_ROUTE_W  = 5;
    localparam int CH_MIX_MIN_WAIT = 3;

    // Headroom: +1 for op1+op2, +1 for the x2 route, log2(channels) for the sum, +1 sign margin.
    function automatic int CH_MIX_ACC_WIDTH(input int op_w, input int nch);
        return op_w + 2 + $clog2(nch) + 1;
    endfunction

    // WAIT never drops below 3 cycles so the slot stays 6 cycles for short latencies.
    function automatic int ch_mix_wait_cycles(input int rd_lat);
        return (rd_lat > CH_MIX_MIN_WAIT) ? rd_lat : CH_MIX_MIN_WAIT;
    endfunction

endpackage

// File: rtl/channel_mixer_if.sv
// Stereo result stream from the mixer towards dac_prep or a FIFO.
interface channel_mixer_if #(
    parameter int OUT_WIDTH = 16
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_l;
    logic signed [OUT_WIDTH-1:0] out_r;
    logic                        clip_l;
    logic                        clip_r;

    modport master (
        output out_valid, out_l, out_r, clip_l, clip_r,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_l, out_r, clip_l, clip_r,
        output out_ready
    );
endinterface

// File: rtl/channel_mixer_sat_clamp.sv
// Combinational signed clamp from IN_WIDTH to OUT_WIDTH with a clip flag.
module sat_clamp #(
    parameter int IN_WIDTH  = 21,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  in_val,
    output logic signed [OUT_WIDTH-1:0] out_val,
    output logic                        clip
);
    // Value fits when every bit from the output sign bit upward agrees.
    logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
    assign top_bits = in_val[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        clip = !((&top_bits) || !(|top_bits));
        if (!clip)
            out_val = in_val[OUT_WIDTH-1:0];
        else if (in_val[IN_WIDTH-1])
            out_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            out_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
endmodule

// File: rtl/channel_mixer.sv
// Walks the operator-output memory once per sample, mixes each 2-op channel
// into L/R accumulators and presents one saturated stereo sample.
module channel_mixer
    import channel_mixer_pkg::*;
#(
    parameter int NUM_CHANNELS = 18,
    parameter int OP_OUT_WIDTH = 13,
    parameter int OUT_WIDTH    = 16,
    parameter int RD_LATENCY   = 1,
    parameter int ATTEN_WIDTH  = 2
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  op_rd_en,
    output logic [$clog2(2*NUM_CHANNELS)-1:0]     op_rd_addr,
    input  logic signed [OP_OUT_WIDTH-1:0]        op_rd_data,
    input  logic                                  cfg_wr,
    input  logic [$clog2(NUM_CHANNELS)-1:0]       cfg_addr,
    input  logic [CH_MIX_ROUTE_W+ATTEN_WIDTH-1:0] cfg_data,
    output logic                                  overrun,
    channel_mixer_if.master                       out_if
);
    localparam int CHW      = $clog2(NUM_CHANNELS);
    localparam int CFG_W    = CH_MIX_ROUTE_W + ATTEN_WIDTH;
    localparam int ACC_W    = CH_MIX_ACC_WIDTH(OP_OUT_WIDTH, NUM_CHANNELS);
    localparam int VW       = OP_OUT_WIDTH + 1;
    localparam int WAIT_CYC = ch_mix_wait_cycles(RD_LATENCY);
    localparam logic [1:0]     WAIT_INIT = 2'(WAIT_CYC - 1);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CHANNELS - 1);
    localparam logic [CHW:0]   NUM_CH_W  = (CHW+1)'(NUM_CHANNELS);

    channel_mixer_state_t state_q, state_d;
    logic [CHW-1:0]                    ch_q, ch_d;
    logic [1:0]                        wait_q, wait_d;
    logic [NUM_CHANNELS-1:0][CFG_W-1:0] cfg_q, cfg_d;
    logic [CFG_W-1:0]                  cur_cfg_q, cur_cfg_d;
    logic signed [OP_OUT_WIDTH-1:0]    op1_q, op1_d, op2_q, op2_d;
    logic signed [ACC_W-1:0]           acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [RD_LATENCY-1:0]             vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0]             sel_pipe_q, sel_pipe_d;
    logic                              out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0]       out_l_q, out_l_d, out_r_q, out_r_d;
    logic                              clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                              overrun_q, overrun_d;

    // Channel value from the snapshotted config.
    channel_cfg_t             route;
    logic [ATTEN_WIDTH-1:0]   atten;
    logic signed [VW-1:0]     v_sum, v_sh;
    logic signed [ACC_W-1:0]  v_ext, add_l, add_r;

    assign route = channel_cfg_t'(cur_cfg_q[CH_MIX_ROUTE_W-1:0]);
    assign atten = cur_cfg_q[CFG_W-1:CH_MIX_ROUTE_W];

    always_comb begin
        v_sum = route.cnt ? (VW'(op1_q) + VW'(op2_q)) : VW'(op2_q);
        v_sh  = v_sum >>> atten;
        v_ext = ACC_W'(v_sh);
        unique case ({route.cha, route.chc})
            2'b00:   add_l = '0;
            2'b11:   add_l = v_ext <<< 1;
            default: add_l = v_ext;
        endcase
        unique case ({route.chb, route.chd})
            2'b00:   add_r = '0;
            2'b11:   add_r = v_ext <<< 1;
            default: add_r = v_ext;
        endcase
    end

    logic signed [OUT_WIDTH-1:0] sat_l, sat_r;
    logic                        sat_clip_l, sat_clip_r;

    sat_clamp #(.IN_WIDTH(ACC_W), .OUT_WIDTH(OUT_WIDTH)) u_sat_l (
        .in_val (acc_l_q),
        .out_val(sat_l),
        .clip   (sat_clip_l)
    );

    sat_clamp #(.IN_WIDTH(ACC_W), .OUT_WIDTH(OUT_WIDTH)) u_sat_r (
        .in_val (acc_r_q),
        .out_val(sat_r),
        .clip   (sat_clip_r)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wait_d      = wait_q;
        cfg_d       = cfg_q;
        cur_cfg_d   = cur_cfg_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        out_valid_d = out_valid_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        clip_l_d    = clip_l_q;
        clip_r_d    = clip_r_q;
        overrun_d   = overrun_q;
        busy        = 1'b0;
        op_rd_en    = 1'b0;
        op_rd_addr  = '0;
        vld_pipe_d  = '0;
        sel_pipe_d  = '0;

        // Read-return tracking: sel=1 marks the second operator (op2).
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            sel_pipe_d[i] = sel_pipe_q[i-1];
        end
        if (vld_pipe_q[RD_LATENCY-1]) begin
            if (sel_pipe_q[RD_LATENCY-1]) op2_d = op_rd_data;
            else                          op1_d = op_rd_data;
        end

        if (cfg_wr && ({1'b0, cfg_addr} < NUM_CH_W))
            cfg_d[cfg_addr] = cfg_data;

        if (out_valid_q && out_if.out_ready)
            out_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OUT: begin
                if (start) begin
                    acc_l_d = '0;
                    acc_r_d = '0;
                    ch_d    = '0;
                    state_d = ST_FETCH0;
                end
            end
            ST_FETCH0: begin
                busy          = 1'b1;
                op_rd_en      = 1'b1;
                op_rd_addr    = {ch_q, 1'b1};
                vld_pipe_d[0] = 1'b1;
                sel_pipe_d[0] = 1'b1;
                cur_cfg_d     = cfg_q[ch_q];
                state_d       = ST_FETCH1;
            end
            ST_FETCH1: begin
                busy          = 1'b1;
                op_rd_en      = 1'b1;
                op_rd_addr    = {ch_q, 1'b0};
                vld_pipe_d[0] = 1'b1;
                wait_d        = WAIT_INIT;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_q == 2'd0) state_d = ST_ACCUM;
                else                wait_d  = wait_q - 2'd1;
            end
            ST_ACCUM: begin
                busy    = 1'b1;
                acc_l_d = acc_l_q + add_l;
                acc_r_d = acc_r_q + add_r;
                if (ch_q == LAST_CH) begin
                    state_d = ST_SAT;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = ST_FETCH0;
                end
            end
            ST_SAT: begin
                busy        = 1'b1;
                out_l_d     = sat_l;
                out_r_d     = sat_r;
                clip_l_d    = sat_clip_l;
                clip_r_d    = sat_clip_r;
                out_valid_d = 1'b1;
                // Same-cycle acceptance frees the slot, so only an unaccepted result counts.
                if (out_valid_q && !out_if.out_ready) overrun_d = 1'b1;
                state_d     = ST_OUT;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start && busy) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            wait_q      <= '0;
            cfg_q       <= '0;
            cur_cfg_q   <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            vld_pipe_q  <= '0;
            sel_pipe_q  <= '0;
            out_valid_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wait_q      <= wait_d;
            cfg_q       <= cfg_d;
            cur_cfg_q   <= cur_cfg_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            vld_pipe_q  <= vld_pipe_d;
            sel_pipe_q  <= sel_pipe_d;
            out_valid_q <= out_valid_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            clip_l_q    <= clip_l_d;
            clip_r_q    <= clip_r_d;
            overrun_q   <= overrun_d;
        end
    end

    assign overrun          = overrun_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_l     = out_l_q;
    assign out_if.out_r     = out_r_q;
    assign out_if.clip_l    = clip_l_q;
    assign out_if.clip_r    = clip_r_q;

endmodule

// File: tb/tb_channel_mixer.sv
// Directed bench: an 18-channel/latency-1 mixer and a 4-channel/latency-3 mixer.
module tb_channel_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat;

    // DUT 1: defaults
    logic              rst1_n, start1, busy1, rd_en1, cfg_wr1, ovr1;
    logic [5:0]        rd_addr1;
    logic signed [12:0] rd_data1;
    logic [4:0]        cfg_addr1;
    logic [6:0]        cfg_data1;
    logic signed [12:0] mem1 [36];
    channel_mixer_if #(.OUT_WIDTH(16)) o1 ();

    channel_mixer #(.NUM_CHANNELS(18), .OP_OUT_WIDTH(13), .OUT_WIDTH(16),
                    .RD_LATENCY(1), .ATTEN_WIDTH(2)) dut1 (
        .clk(clk), .reset_n(rst1_n), .start(start1), .busy(busy1),
        .op_rd_en(rd_en1), .op_rd_addr(rd_addr1), .op_rd_data(rd_data1),
        .cfg_wr(cfg_wr1), .cfg_addr(cfg_addr1), .cfg_data(cfg_data1),
        .overrun(ovr1), .out_if(o1)
    );

    always @(posedge clk) rd_data1 <= mem1[rd_addr1];

    // DUT 2: 4 channels, read latency 3
    logic              rst2_n, start2, busy2, rd_en2, cfg_wr2, ovr2;
    logic [2:0]        rd_addr2;
    logic signed [12:0] rd_data2, p2a, p2b;
    logic [1:0]        cfg_addr2;
    logic [6:0]        cfg_data2;
    logic signed [12:0] mem2 [8];
    channel_mixer_if #(.OUT_WIDTH(16)) o2 ();

    channel_mixer #(.NUM_CHANNELS(4), .OP_OUT_WIDTH(13), .OUT_WIDTH(16),
                    .RD_LATENCY(3), .ATTEN_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(rst2_n), .start(start2), .busy(busy2),
        .op_rd_en(rd_en2), .op_rd_addr(rd_addr2), .op_rd_data(rd_data2),
        .cfg_wr(cfg_wr2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
        .overrun(ovr2), .out_if(o2)
    );

    always @(posedge clk) begin
        p2a      <= mem2[rd_addr2];
        p2b      <= p2a;
        rd_data2 <= p2b;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg1(input logic [4:0] a, input logic [6:0] d);
        cfg_wr1 = 1'b1; cfg_addr1 = a; cfg_data1 = d;
        @(posedge clk); #1;
        cfg_wr1 = 1'b0;
    endtask

    task automatic cfg2(input logic [1:0] a, input logic [6:0] d);
        cfg_wr2 = 1'b1; cfg_addr2 = a; cfg_data2 = d;
        @(posedge clk); #1;
        cfg_wr2 = 1'b0;
    endtask

    // Latency = edges from driving start until busy falls (the edge that raises out_valid).
    task automatic run1(input int extra_at, output int l);
        bit seen = 1'b0;
        l = -1;
        start1 = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
            if (busy1) seen = 1'b1;
            else if (seen) begin l = n; break; end
            if (n == extra_at) start1 = 1'b1;
        end
    endtask

    task automatic run2(output int l);
        bit seen = 1'b0;
        l = -1;
        start2 = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (busy2) seen = 1'b1;
            else if (seen) begin l = n; break; end
        end
    endtask

    initial begin
        rst1_n = 1'b0; start1 = 1'b0; cfg_wr1 = 1'b0; cfg_addr1 = '0; cfg_data1 = '0;
        rst2_n = 1'b0; start2 = 1'b0; cfg_wr2 = 1'b0; cfg_addr2 = '0; cfg_data2 = '0;
        o1.out_ready = 1'b0; o2.out_ready = 1'b0;
        for (int i = 0; i < 36; i++) mem1[i] = 13'(i + 1);
        for (int i = 0; i < 8; i++)  mem2[i] = 13'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o1.out_valid, 0);
        check("rst_busy", busy1, 0);
        check("rst_overrun", ovr1, 0);
        check("rst_out_l", o1.out_l, 0);
        check("rst_rd_en", rd_en1, 0);
        rst1_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;

        // 1: ch0 cnt|cha|chb, out-of-range cfg write ignored
        cfg1(5'd0, 7'h07);
        cfg1(5'd31, 7'h1F);
        run1(0, lat);
        check("t1_latency", lat, 110);
        check("t1_valid", o1.out_valid, 1);
        check("t1_out_l", o1.out_l, 3);
        check("t1_out_r", o1.out_r, 3);
        check("t1_clip_l", o1.clip_l, 0);
        o1.out_ready = 1'b1; @(posedge clk); #1; o1.out_ready = 1'b0;

        // 2: ch0 cha|chc, no cnt, atten 1 -> (2>>>1)*2
        cfg1(5'd0, 7'h2A);
        run1(0, lat);
        check("t2_out_l", o1.out_l, 2);
        check("t2_out_r", o1.out_r, 0);
        o1.out_ready = 1'b1; @(posedge clk); #1; o1.out_ready = 1'b0;

        // 3: full-scale saturation both polarities
        for (int c = 0; c < 18; c++) cfg1(5'(c), 7'h1F);
        for (int i = 0; i < 36; i++) mem1[i] = 13'sd4095;
        run1(0, lat);
        check("t3_pos_l", o1.out_l, 32767);
        check("t3_pos_r", o1.out_r, 32767);
        check("t3_pos_clip_l", o1.clip_l, 1);
        check("t3_pos_clip_r", o1.clip_r, 1);
        o1.out_ready = 1'b1; @(posedge clk); #1; o1.out_ready = 1'b0;
        for (int i = 0; i < 36; i++) mem1[i] = -13'sd4096;
        run1(0, lat);
        check("t3_neg_l", o1.out_l, -32768);
        check("t3_neg_r", o1.out_r, -32768);
        check("t3_neg_clip_l", o1.clip_l, 1);
        check("t3_neg_clip_r", o1.clip_r, 1);
        o1.out_ready = 1'b1; @(posedge clk); #1; o1.out_ready = 1'b0;

        // 4a: unaccepted result overwritten by the next sample
        for (int i = 0; i < 36; i++) mem1[i] = 13'(i + 1);
        run1(0, lat);
        check("t4_first_l", o1.out_l, 1332);
        check("t4_first_clip", o1.clip_l, 0);
        check("t4_first_ovr", ovr1, 0);
        cfg1(5'd0, 7'h00);
        run1(0, lat);
        check("t4_second_lat", lat, 110);
        check("t4_overwrite_l", o1.out_l, 1326);
        check("t4_overwrite_r", o1.out_r, 1326);
        check("t4_still_valid", o1.out_valid, 1);
        check("t4_overrun", ovr1, 1);
        o1.out_ready = 1'b1;
        @(posedge clk); #1;
        o1.out_ready = 1'b0;
        check("t4_valid_drop", o1.out_valid, 0);
        check("t4_overrun_sticky", ovr1, 1);

        // 4b: start while busy is dropped
        rst1_n = 1'b0; #2; rst1_n = 1'b1;
        check("t4_ovr_cleared", ovr1, 0);
        @(posedge clk); #1;
        cfg1(5'd0, 7'h07);
        run1(20, lat);
        check("t4_busy_start_lat", lat, 110);
        check("t4_busy_start_ovr", ovr1, 1);
        check("t4_busy_start_l", o1.out_l, 3);
        repeat (120) @(posedge clk);
        #1;
        check("t4_no_restart", busy1, 0);

        // 5: latency-3 instance, reset mid-sample then a clean run
        cfg2(2'd1, 7'h13);
        cfg2(2'd3, 7'h44);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("t5_busy_mid", busy2, 1);
        rst2_n = 1'b0;
        #1;
        check("t5_rst_valid", o2.out_valid, 0);
        check("t5_rst_busy", busy2, 0);
        check("t5_rst_rd_en", rd_en2, 0);
        check("t5_rst_out_l", o2.out_l, 0);
        check("t5_rst_ovr", ovr2, 0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t5_no_partial", o2.out_valid, 0);
        cfg2(2'd1, 7'h13);
        cfg2(2'd3, 7'h44);
        run2(lat);
        check("t5_latency", lat, 26);
        check("t5_out_l", o2.out_l, 7);
        check("t5_out_r", o2.out_r, 9);
        check("t5_valid", o2.out_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
